// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: zero-fills a 256x16 single-port masked-write SRAM after reset, then
// arbitrates its RW port between one writer and two round-robin readers (writes win,
// except a read that has lost STARVE_MAX times in a row is forced ahead).
// Latency: write lands at the end of its grant cycle; read data returns one cycle after grant.
// Backpressure: *_ready equals the grant (combinational on *_valid), zero during INIT/reset.
// Ports: clock/reset; w_* write request; r0_*/r1_* read requests; rresp0_*/rresp1_*
// tagged read responses; init_done; sram_* macro RW port with sram_rdata return.
module sram_arb_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W-1:0] w_mask,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              rresp0_valid,
    output logic [DATA_W-1:0] rresp0_data,
    output logic              rresp1_valid,
    output logic [DATA_W-1:0] rresp1_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic              rr_ptr_q, rr_ptr_d;      // 0: port 0 wins a tie
    logic              resp_vld_q, resp_vld_d;
    logic              resp_port_q, resp_port_d;
    logic              init_done_q, init_done_d;

    logic any_rd;
    logic force_rd;
    logic pick_r1;

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        starve_cnt_d = starve_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        resp_vld_d   = 1'b0;
        resp_port_d  = resp_port_q;
        init_done_d  = init_done_q;
        w_ready      = 1'b0;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        sram_en      = 1'b0;
        sram_wmode   = 1'b0;
        sram_addr    = '0;
        sram_wmask   = '0;
        sram_wdata   = '0;

        any_rd   = r0_valid | r1_valid;
        force_rd = any_rd && (starve_cnt_q == SC_W'(STARVE_MAX));
        // Tie goes to the port rr_ptr names; a lone request simply wins.
        pick_r1  = r1_valid && (!r0_valid || rr_ptr_q);

        // Reset is synchronous, so the port must be quieted combinationally too.
        if (!reset) begin
            case (state_q)
                ST_INIT: begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = init_cnt_q;
                    sram_wmask = '1;
                    sram_wdata = '0;
                    init_cnt_d = init_cnt_q + 1'b1;
                    if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_valid && !force_rd) begin
                        w_ready    = 1'b1;
                        sram_en    = 1'b1;
                        sram_wmode = 1'b1;
                        sram_addr  = w_addr;
                        sram_wmask = w_mask;
                        sram_wdata = w_data;
                        if (any_rd && (starve_cnt_q != SC_W'(STARVE_MAX)))
                            starve_cnt_d = starve_cnt_q + 1'b1;
                    end else if (any_rd) begin
                        r0_ready     = !pick_r1;
                        r1_ready     = pick_r1;
                        sram_en      = 1'b1;
                        sram_addr    = pick_r1 ? r1_addr : r0_addr;
                        starve_cnt_d = '0;
                        resp_vld_d   = 1'b1;
                        resp_port_d  = pick_r1;
                        if (r0_valid && r1_valid)
                            rr_ptr_d = !pick_r1;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            starve_cnt_q <= '0;
            rr_ptr_q     <= 1'b0;
            resp_vld_q   <= 1'b0;
            resp_port_q  <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_vld_q   <= resp_vld_d;
            resp_port_q  <= resp_port_d;
            init_done_q  <= init_done_d;
        end
    end

    // A response registered just before reset rises is suppressed by the reset gate.
    assign rresp0_valid = resp_vld_q && !resp_port_q && !reset;
    assign rresp1_valid = resp_vld_q &&  resp_port_q && !reset;
    assign rresp0_data  = sram_rdata;
    assign rresp1_data  = sram_rdata;
    assign init_done    = init_done_q && !reset;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Testbench for sram_arb_ctrl with a behavioural masked-write SRAM behind the macro port.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
// Directed vectors: init sweep, masked write/read, round-robin, starvation, resets.
module tb_sram_arb_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        w_valid, w_ready;
    logic [7:0]  w_addr;
    logic [15:0] w_data, w_mask;
    logic        r0_valid, r0_ready;
    logic [7:0]  r0_addr;
    logic        r1_valid, r1_ready;
    logic [7:0]  r1_addr;
    logic        rresp0_valid, rresp1_valid;
    logic [15:0] rresp0_data, rresp1_data;
    logic        init_done;
    logic        sram_en, sram_wmode;
    logic [7:0]  sram_addr;
    logic [15:0] sram_wmask, sram_wdata;
    logic [15:0] sram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [256];

    sram_arb_ctrl dut (
        .clock(clock), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr),
        .w_data(w_data), .w_mask(w_mask),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
        .rresp0_valid(rresp0_valid), .rresp0_data(rresp0_data),
        .rresp1_valid(rresp1_valid), .rresp1_data(rresp1_data),
        .init_done(init_done),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clock = ~clock;

    // SRAM macro model: masked write, one-cycle registered read.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode)
                mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
            else
                sram_rdata <= mem[sram_addr];
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        w_valid  = 1'b0;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic port, input logic [15:0] data);
        chk_eq(tag, {rresp0_valid, rresp1_valid, (port ? rresp1_data : rresp0_data)},
               {!port, port, data});
    endtask

    // Walks n init cycles from the current one (cycle 0 first), with all requests
    // asserted so any leaked ready shows up.
    task automatic sweep(input int n);
        for (int k = 0; k < n; k++) begin
            w_valid = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
            #2;
            chk_eq("init_port",
                   {sram_en, sram_wmode, sram_addr, sram_wdata, sram_wmask,
                    w_ready, r0_ready, r1_ready, init_done, rresp0_valid, rresp1_valid},
                   {1'b1, 1'b1, 8'(k), 16'h0000, 16'hFFFF, 6'b0});
            cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 16'hDEAD;
        reset = 1'b1;
        idle();
        w_addr = '0; w_data = '0; w_mask = '0; r0_addr = '0; r1_addr = '0;
        cyc(); cyc();

        // Reset: nothing granted, no responses, init_done low.
        w_valid = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
        #2;
        chk_eq("reset_outputs",
               {sram_en, w_ready, r0_ready, r1_ready, rresp0_valid, rresp1_valid, init_done}, 7'b0);
        cyc();
        reset = 1'b0;

        // Full zero sweep, then first grant in cycle 256.
        sweep(256);
        idle();
        r0_valid = 1'b1; r0_addr = 8'h7F;
        #2;
        chk_eq("init_done_256", init_done, 1'b1);
        chk_eq("rd7f_grant", {r0_ready, r1_ready, w_ready, sram_en, sram_wmode, sram_addr, sram_wmask},
               {5'b10010, 8'h7F, 16'h0000});
        cyc();
        idle();
        #2;
        chk_resp("rd7f_resp", 1'b0, 16'h0000);

        // Masked write then read-after-write.
        cyc();
        w_valid = 1'b1; w_addr = 8'h10; w_data = 16'hABCD; w_mask = 16'hFFFF;
        #2;
        chk_eq("wr_full", {w_ready, sram_en, sram_wmode, sram_addr, sram_wdata, sram_wmask},
               {3'b111, 8'h10, 16'hABCD, 16'hFFFF});
        cyc();
        w_data = 16'h1234; w_mask = 16'h00FF;
        #2;
        chk_eq("wr_masked", {w_ready, sram_wdata, sram_wmask}, {1'b1, 16'h1234, 16'h00FF});
        cyc();
        idle();
        r0_valid = 1'b1; r0_addr = 8'h10;
        #2;
        chk_eq("raw_grant", {r0_ready, sram_wmode, sram_addr}, {2'b10, 8'h10});
        cyc();
        idle();
        #2;
        chk_resp("raw_resp", 1'b0, 16'hAB34);
        cyc();
        #2;
        chk_eq("raw_one_shot", {rresp0_valid, rresp1_valid}, 2'b00);

        // Preload for the round-robin and starvation runs.
        w_valid = 1'b1; w_addr = 8'h01; w_data = 16'h1111; w_mask = 16'hFFFF;
        cyc();
        w_addr = 8'h02; w_data = 16'h2222;
        cyc();
        idle();

        // Round-robin: both readers valid for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            r0_valid = 1'b1; r0_addr = 8'h01; r1_valid = 1'b1; r1_addr = 8'h02;
            #2;
            chk_eq("rr_grant", {r0_ready, r1_ready, sram_addr},
                   (i % 2 == 0) ? {2'b10, 8'h01} : {2'b01, 8'h02});
            if (i > 0)
                chk_resp("rr_resp", ((i - 1) % 2) != 0, ((i - 1) % 2 != 0) ? 16'h2222 : 16'h1111);
            cyc();
        end
        idle();
        #2;
        chk_resp("rr_resp_last", 1'b1, 16'h2222);
        cyc();

        // Starvation: continuous writes with r0 pending.
        for (int i = 0; i < 10; i++) begin
            w_valid = 1'b1; w_addr = 8'h30; w_data = 16'(i); w_mask = 16'hFFFF;
            r0_valid = 1'b1; r0_addr = 8'h01;
            #2;
            chk_eq("starve_grant", {w_ready, r0_ready},
                   (i == 4 || i == 9) ? 2'b01 : 2'b10);
            if (i == 5) chk_resp("starve_resp", 1'b0, 16'h1111);
            cyc();
        end
        idle();
        #2;
        chk_resp("starve_resp2", 1'b0, 16'h1111);
        cyc();

        // Reset right after an r1 grant: the pending response must never appear.
        r1_valid = 1'b1; r1_addr = 8'h02;
        #2;
        chk_eq("r1_grant", {r0_ready, r1_ready, sram_addr}, {2'b01, 8'h02});
        cyc();
        idle();
        reset = 1'b1;
        #2;
        chk_eq("rst_drop_resp", {rresp0_valid, rresp1_valid, sram_en, init_done}, 4'b0);
        cyc();
        #2;
        chk_eq("rst_hold", {rresp0_valid, rresp1_valid, sram_en, init_done}, 4'b0);
        cyc();
        reset = 1'b0;

        // Sweep restarts at 0; reset again at init_cnt = 100.
        sweep(100);
        #2;
        chk_eq("mid_init_addr", {sram_en, sram_addr}, {1'b1, 8'd100});
        reset = 1'b1;
        #1;
        chk_eq("mid_init_rst_en", sram_en, 1'b0);
        cyc();
        reset = 1'b0;
        sweep(256);
        idle();
        r0_valid = 1'b1; r0_addr = 8'h10;
        #2;
        chk_eq("reinit_done", {init_done, r0_ready}, 2'b11);
        cyc();
        idle();
        #2;
        chk_resp("reinit_zeroed", 1'b0, 16'h0000);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
